// File: rtl/regfile_pkg.sv
// Shared constants for the pipelined two-read/one-write register file.
// The top module takes its default geometry from here.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: request/hold handshake, write-to-read bypass,
// r0 forced to zero, and output data gated by valid.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    req,
  input  logic [ADDR_WIDTH_P-1:0] idx,
  input  logic                    hold,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH_P-1:0] write_index,
  input  logic [DATA_WIDTH_P-1:0] write_data,
  input  logic [DATA_WIDTH_P-1:0] array_data,
  output logic                    ready,
  output logic                    valid,
  output logic [DATA_WIDTH_P-1:0] data
);

  logic                    accept;
  logic                    is_zero;
  logic                    bypass;
  logic [DATA_WIDTH_P-1:0] read_value;
  logic [DATA_WIDTH_P-1:0] data_reg;

  assign ready   = !(valid && hold);
  assign accept  = req && ready;
  assign is_zero = (idx == ADDR_WIDTH_P'(REG_ZERO));
  assign bypass  = write_enable && (write_index == idx);

  // r0 wins over bypass so a discarded write to index 0 never leaks out.
  always_comb begin
    read_value = array_data;
    if (is_zero) begin
      read_value = '0;
    end else if (bypass) begin
      read_value = write_data;
    end
  end

  // A held result keeps both valid and its snapshot; later writes cannot touch it.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      valid    <= 1'b0;
      data_reg <= '0;
    end else if (accept) begin
      valid    <= 1'b1;
      data_reg <= read_value;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

  assign data = data_reg & {DATA_WIDTH_P{valid}};

endmodule

// File: rtl/regfile_2r1w_pipe.sv
// Register file with one write port and two independent registered read ports.
// Storage and write logic live here; each read port is a regfile_read_port.
module regfile_2r1w_pipe
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_WIDTH_P-1:0] ctrl_writeRegister,
  input  logic [DATA_WIDTH_P-1:0] data_writeReg,
  input  logic                    rd_req_a,
  input  logic [ADDR_WIDTH_P-1:0] ctrl_readRegA,
  input  logic                    rd_hold_a,
  input  logic                    rd_req_b,
  input  logic [ADDR_WIDTH_P-1:0] ctrl_readRegB,
  input  logic                    rd_hold_b,
  output logic                    rd_ready_a,
  output logic                    rd_valid_a,
  output logic [DATA_WIDTH_P-1:0] data_readRegA,
  output logic                    rd_ready_b,
  output logic                    rd_valid_b,
  output logic [DATA_WIDTH_P-1:0] data_readRegB
);

  localparam int NUM_REGS_P = 2 ** ADDR_WIDTH_P;

  logic [DATA_WIDTH_P-1:0] regs [NUM_REGS_P];
  logic                    write_active;

  assign write_active = ctrl_writeEnable &&
                        (ctrl_writeRegister != ADDR_WIDTH_P'(REG_ZERO));

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS_P; i++) begin
        regs[i] <= '0;
      end
    end else if (write_active) begin
      regs[ctrl_writeRegister] <= data_writeReg;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH_P(DATA_WIDTH_P),
    .ADDR_WIDTH_P(ADDR_WIDTH_P)
  ) u_port_a (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .req          (rd_req_a),
    .idx          (ctrl_readRegA),
    .hold         (rd_hold_a),
    .write_enable (write_active),
    .write_index  (ctrl_writeRegister),
    .write_data   (data_writeReg),
    .array_data   (regs[ctrl_readRegA]),
    .ready        (rd_ready_a),
    .valid        (rd_valid_a),
    .data         (data_readRegA)
  );

  regfile_read_port #(
    .DATA_WIDTH_P(DATA_WIDTH_P),
    .ADDR_WIDTH_P(ADDR_WIDTH_P)
  ) u_port_b (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .req          (rd_req_b),
    .idx          (ctrl_readRegB),
    .hold         (rd_hold_b),
    .write_enable (write_active),
    .write_index  (ctrl_writeRegister),
    .write_data   (data_writeReg),
    .array_data   (regs[ctrl_readRegB]),
    .ready        (rd_ready_b),
    .valid        (rd_valid_b),
    .data         (data_readRegB)
  );

endmodule

// File: tb/tb_regfile_2r1w_pipe.sv
// Self-checking bench for regfile_2r1w_pipe: directed scenarios plus a random
// run, all compared against an array-based reference model.
module tb_regfile_2r1w_pipe;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeRegister;
  logic [31:0] data_writeReg;
  logic        rd_req_a, rd_req_b;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic        rd_hold_a, rd_hold_b;
  logic        rd_ready_a, rd_ready_b;
  logic        rd_valid_a, rd_valid_b;
  logic [31:0] data_readRegA, data_readRegB;

  int n_checks;
  int n_fail;

  logic [31:0] mem [32];
  logic        mv_a, mv_b;
  logic [31:0] md_a, md_b;

  regfile_2r1w_pipe dut (
    .clock              (clock),
    .ctrl_reset_n       (ctrl_reset_n),
    .ctrl_writeEnable   (ctrl_writeEnable),
    .ctrl_writeRegister (ctrl_writeRegister),
    .data_writeReg      (data_writeReg),
    .rd_req_a           (rd_req_a),
    .ctrl_readRegA      (ctrl_readRegA),
    .rd_hold_a          (rd_hold_a),
    .rd_req_b           (rd_req_b),
    .ctrl_readRegB      (ctrl_readRegB),
    .rd_hold_b          (rd_hold_b),
    .rd_ready_a         (rd_ready_a),
    .rd_valid_a         (rd_valid_a),
    .data_readRegA      (data_readRegA),
    .rd_ready_b         (rd_ready_b),
    .rd_valid_b         (rd_valid_b),
    .data_readRegB      (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Value a read of idx would capture this cycle, straight from the behavioural rules.
  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (ctrl_writeEnable && ctrl_writeRegister == idx) return data_writeReg;
    return mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mv_a = 1'b0; mv_b = 1'b0; md_a = 32'h0; md_b = 32'h0;
  endtask

  task automatic model_clock();
    logic [31:0] va, vb;
    bit ra, rb;
    va = model_read(ctrl_readRegA);
    vb = model_read(ctrl_readRegB);
    ra = !(mv_a && rd_hold_a);
    rb = !(mv_b && rd_hold_b);
    if (rd_req_a && ra) begin mv_a = 1'b1; md_a = va; end
    else if (ra) mv_a = 1'b0;
    if (rd_req_b && rb) begin mv_b = 1'b1; md_b = vb; end
    else if (rb) mv_b = 1'b0;
    if (ctrl_writeEnable && ctrl_writeRegister != 5'd0) mem[ctrl_writeRegister] = data_writeReg;
  endtask

  // Inputs change only at negedge, so DUT and model see the same values at posedge.
  task automatic step();
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    ctrl_writeEnable = 1'b0; ctrl_writeRegister = 5'd0; data_writeReg = 32'h0;
    rd_req_a = 1'b0; rd_req_b = 1'b0; ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    rd_hold_a = 1'b0; rd_hold_b = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ctrl_reset_n = 1'b1;
    #1 ctrl_reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid: got a=%b b=%b expected 0 0", rd_valid_a, rd_valid_b);
    end
    n_checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got a=%h b=%h expected 0 0", data_readRegA, data_readRegB);
    end
    ctrl_reset_n = 1'b1;
    #1;
    n_checks++;
    if (rd_ready_a !== 1'b1 || rd_ready_b !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_ready: got a=%b b=%b expected 1 1", rd_ready_a, rd_ready_b);
    end
    @(negedge clock);
  endtask

  task automatic test_read_after_write();
    ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'd5; data_writeReg = 32'hDEADBEEF;
    step();
    ctrl_writeEnable = 1'b0; rd_req_a = 1'b1; ctrl_readRegA = 5'd5;
    step();
    rd_req_a = 1'b0;
    n_checks++;
    if (rd_valid_a !== 1'b1 || data_readRegA !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL read_r5: got v=%b d=%h expected 1 deadbeef", rd_valid_a, data_readRegA);
    end
    step();
    n_checks++;
    if (rd_valid_a !== 1'b0 || data_readRegA !== 32'h0) begin
      n_fail++; $display("[TB] FAIL read_r5_drop: got v=%b d=%h expected 0 0", rd_valid_a, data_readRegA);
    end
  endtask

  task automatic test_bypass();
    ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'd3; data_writeReg = 32'h1234;
    rd_req_b = 1'b1; ctrl_readRegB = 5'd3;
    step();
    idle_inputs();
    n_checks++;
    if (rd_valid_b !== 1'b1 || data_readRegB !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL bypass_b: got v=%b d=%h expected 1 1234", rd_valid_b, data_readRegB);
    end
    step();
  endtask

  task automatic test_r0();
    ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'd0; data_writeReg = 32'hFFFFFFFF;
    rd_req_b = 1'b1; ctrl_readRegB = 5'd0;
    step();
    ctrl_writeEnable = 1'b0; rd_req_b = 1'b0; rd_req_a = 1'b1; ctrl_readRegA = 5'd0;
    n_checks++;
    if (rd_valid_b !== 1'b1 || data_readRegB !== 32'h0) begin
      n_fail++; $display("[TB] FAIL r0_bypass: got v=%b d=%h expected 1 0", rd_valid_b, data_readRegB);
    end
    step();
    rd_req_a = 1'b0;
    n_checks++;
    if (rd_valid_a !== 1'b1 || data_readRegA !== 32'h0) begin
      n_fail++; $display("[TB] FAIL r0_read: got v=%b d=%h expected 1 0", rd_valid_a, data_readRegA);
    end
    step();
  endtask

  task automatic test_hold();
    ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'd7; data_writeReg = 32'h55;
    step();
    ctrl_writeEnable = 1'b0; rd_req_a = 1'b1; ctrl_readRegA = 5'd7;
    step();
    for (int c = 0; c < 3; c++) begin
      rd_hold_a = 1'b1; ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'd7; data_writeReg = 32'hAA;
      #1;
      n_checks++;
      if (rd_ready_a !== 1'b0 || rd_valid_a !== 1'b1 || data_readRegA !== 32'h55) begin
        n_fail++; $display("[TB] FAIL hold_cycle%0d: got rdy=%b v=%b d=%h expected 0 1 55",
                           c, rd_ready_a, rd_valid_a, data_readRegA);
      end
      step();
    end
    rd_hold_a = 1'b0; ctrl_writeEnable = 1'b0;
    #1;
    n_checks++;
    if (rd_ready_a !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hold_release_ready: got %b expected 1", rd_ready_a);
    end
    step();
    rd_req_a = 1'b0;
    n_checks++;
    if (rd_valid_a !== 1'b1 || data_readRegA !== 32'hAA) begin
      n_fail++; $display("[TB] FAIL hold_new_read: got v=%b d=%h expected 1 aa", rd_valid_a, data_readRegA);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    for (int c = 0; c < 3; c++) begin
      rd_hold_b = 1'(c & 1);
      step();
      n_checks++;
      if (rd_valid_a !== 1'b0 || data_readRegA !== 32'h0 || rd_valid_b !== 1'b0 || data_readRegB !== 32'h0) begin
        n_fail++; $display("[TB] FAIL idle_cycle%0d: got va=%b da=%h vb=%b db=%h expected all 0",
                           c, rd_valid_a, data_readRegA, rd_valid_b, data_readRegB);
      end
    end
    rd_hold_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'(c + 1); data_writeReg = vals[c];
      step();
    end
    ctrl_writeEnable = 1'b0;
    rd_req_a = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ctrl_readRegA = 5'(c + 1);
      if (c == 3) rd_req_a = 1'b0;
      if (c > 0) begin
        n_checks++;
        if (rd_valid_a !== 1'b1 || data_readRegA !== vals[c-1]) begin
          n_fail++; $display("[TB] FAIL b2b_r%0d: got v=%b d=%h expected 1 %h",
                             c, rd_valid_a, data_readRegA, vals[c-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      ctrl_writeEnable   = 1'($urandom_range(0, 1));
      ctrl_writeRegister = 5'($urandom_range(0, 7));
      data_writeReg      = $urandom;
      rd_req_a = 1'($urandom_range(0, 3) != 0); ctrl_readRegA = 5'($urandom_range(0, 7));
      rd_req_b = 1'($urandom_range(0, 3) != 0); ctrl_readRegB = 5'($urandom_range(0, 7));
      rd_hold_a = 1'($urandom_range(0, 2) == 0);
      rd_hold_b = 1'($urandom_range(0, 2) == 0);
      #1;
      n_checks++;
      if (rd_ready_a !== !(mv_a && rd_hold_a) || rd_ready_b !== !(mv_b && rd_hold_b)) begin
        n_fail++; $display("[TB] FAIL rand_ready%0d: got a=%b b=%b expected %b %b",
                           c, rd_ready_a, rd_ready_b, !(mv_a && rd_hold_a), !(mv_b && rd_hold_b));
      end
      step();
      n_checks++;
      if (rd_valid_a !== mv_a || data_readRegA !== (mv_a ? md_a : 32'h0)) begin
        n_fail++; $display("[TB] FAIL rand_a%0d: got v=%b d=%h expected %b %h",
                           c, rd_valid_a, data_readRegA, mv_a, mv_a ? md_a : 32'h0);
      end
      n_checks++;
      if (rd_valid_b !== mv_b || data_readRegB !== (mv_b ? md_b : 32'h0)) begin
        n_fail++; $display("[TB] FAIL rand_b%0d: got v=%b d=%h expected %b %h",
                           c, rd_valid_b, data_readRegB, mv_b, mv_b ? md_b : 32'h0);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midread();
    ctrl_writeEnable = 1'b1; ctrl_writeRegister = 5'd9; data_writeReg = 32'h77;
    step();
    ctrl_writeEnable = 1'b0; rd_req_a = 1'b1; ctrl_readRegA = 5'd9;
    step();
    n_checks++;
    if (rd_valid_a !== 1'b1 || data_readRegA !== 32'h77) begin
      n_fail++; $display("[TB] FAIL pre_reset_read: got v=%b d=%h expected 1 77", rd_valid_a, data_readRegA);
    end
    #2 ctrl_reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rd_valid_a !== 1'b0 || data_readRegA !== 32'h0) begin
      n_fail++; $display("[TB] FAIL midreset: got v=%b d=%h expected 0 0", rd_valid_a, data_readRegA);
    end
    idle_inputs();
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    rd_req_a = 1'b1; rd_req_b = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      ctrl_readRegA = 5'(i); ctrl_readRegB = 5'(31 - i);
      if (i == 32) begin rd_req_a = 1'b0; rd_req_b = 1'b0; end
      if (i > 0) begin
        n_checks++;
        if (rd_valid_a !== 1'b1 || data_readRegA !== 32'h0 || rd_valid_b !== 1'b1 || data_readRegB !== 32'h0) begin
          n_fail++; $display("[TB] FAIL post_reset_r%0d: got va=%b da=%h vb=%b db=%h expected 1 0 1 0",
                             i - 1, rd_valid_a, data_readRegA, rd_valid_b, data_readRegB);
        end
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_read_after_write();
    test_bypass();
    test_r0();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
